// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_adder_pkg;

    localparam int unsigned STATE_W   = 2;
    localparam int unsigned MIN_WIDTH = 2;
    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fa_bit.sv
// Combinational one-bit full adder: the single arithmetic cell of the serial adder.
module fa_bit (
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    output logic sum_out,
    output logic car_out
);

    assign sum_out = a_in ^ b_in ^ c_in;
    assign car_out = (a_in & b_in) | (a_in & c_in) | (b_in & c_in);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: operands are shifted LSB-first through one
// registered full-adder cell, producing a WIDTH-bit result after WIDTH cycles.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic             sub_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             car_out
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cy_q, cy_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               car_q, car_d;

    logic               fa_sum;
    logic               fa_car;

    fa_bit u_fa_bit (
        .a_in    (a_q[0]),
        .b_in    (b_q[0]),
        .c_in    (cy_q),
        .sum_out (fa_sum),
        .car_out (fa_car)
    );

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        car_d   = car_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    // Subtraction is a + ~b + 1, so invert B and force carry-in.
                    a_d     = a_in;
                    b_d     = sub_in ? ~b_in : b_in;
                    cy_d    = sub_in ? 1'b1 : c_in;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sr_d = {fa_sum, sr_q[WIDTH-1:1]};
                a_d  = {1'b0, a_q[WIDTH-1:1]};
                b_d  = {1'b0, b_q[WIDTH-1:1]};
                cy_d = fa_car;
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {fa_sum, sr_q[WIDTH-1:1]};
                    car_d   = fa_car;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            car_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            car_q   <= car_d;
        end
    end

    assign busy_out = busy_q;
    assign done_out = done_q;
    assign sum_out  = sum_q;
    assign car_out  = car_q;

endmodule
